placement_cost_eval: RTL and testbench
======================================

Name: placement_cost_eval

Overview:
- Downstream stage of the random placer: once placement finishes, walks the edge list and reads the final X/Y position memories.
- Accumulates Manhattan wirelength, 1-hop wirelength and longest edge, and flags edges whose endpoints are unplaced or off-grid.
- Sits between the placer's position RAMs and the reporting/testbench logic; replaces the inline eval states of the placer.

Parameters:
- N, 4, grid side; valid coordinate range 0..N-1
- N_EDGE, 19, number of edges in the edge ROMs
- EDGE_AW, 5, edge ROM address width
- POS_AW, 7, position RAM address width
- DW, 32, data/accumulator width, signed

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins evaluation when idle
- busy  out  1  high while evaluating
- done  out  1  high from end of evaluation until next accepted start
- edge_re  out  1  edge ROM read enable (drives both EA and EB ROMs)
- edge_addr  out  EDGE_AW  edge index
- edge_a  in  DW  node A of the edge; valid the cycle after edge_re
- edge_b  in  DW  node B of the edge; valid the cycle after edge_re
- pos_re  out  1  position RAM read enable (drives X and Y RAMs)
- pos_addr  out  POS_AW  node index
- pos_x  in  DW  X position; valid the cycle after pos_re
- pos_y  in  DW  Y position; valid the cycle after pos_re
- cost_sum  out  DW  sum over edges of |dx|+|dy|-1
- cost_1hop  out  DW  sum over edges of ceil(|dx|/2)+ceil(|dy|/2)-1
- cost_max  out  DW  max over edges of |dx|+|dy|
- err  out  1  sticky; at least one bad edge
- err_edge  out  EDGE_AW  index of the first bad edge

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs are 0; edge_re and pos_re are low.
  - Reset during evaluation aborts immediately. No partial results survive.
- Memory timing: a read issued in cycle t returns data valid in cycle t+1. Data is held until the next read.
- FSM states: IDLE, E_RD, A_RD, B_RD, DIFF, ACC, DONE.
  - IDLE/DONE + start:
    - Clear the accumulators, err, err_edge and the index i.
    - done goes low, busy goes high.
    - Go to E_RD, or straight to DONE if N_EDGE==0.
  - E_RD: assert edge_re, edge_addr=i.
  - A_RD: capture edge_a and edge_b; assert pos_re, pos_addr=edge_a[POS_AW-1:0].
  - B_RD: capture ax, ay; assert pos_re, pos_addr=b.
  - DIFF: capture bx, by; register adx=|ax-bx| and ady=|ay-by|; register bad if any coordinate is <0 or >=N.
  - ACC, when not bad:
    - cost_sum += adx+ady-1
    - cost_1hop += (adx>>1)+adx[0] + (ady>>1)+ady[0] - 1
    - cost_max = max(cost_max, adx+ady)
  - ACC, when bad: no accumulation. If err was 0, set err=1 and err_edge=i.
  - ACC exit: if i==N_EDGE-1 go to DONE (busy=0, done=1); else increment i and go to E_RD.
- Latency: 5 cycles per edge. done rises 5*N_EDGE+1 cycles after the start cycle.
- start while busy is ignored.
- start in DONE restarts evaluation.
- Arithmetic is signed DW-bit and wraps without saturation. A self-loop (a==b) contributes -1 to cost_sum and cost_1hop.
- Unplaced nodes (position -1) count as bad.

Optional Feature:
- Macro COST_CHEBYSHEV_EN.
- When defined:
  - Adds output cost_cheb (DW), the sum over good edges of max(adx,ady)-1.
  - Updated in ACC alongside the other accumulators; reset and clear behaviour as cost_sum.
- When undefined: the port and its logic are absent.

Decomposition:
- Shared package placement_pkg holds:
  - Grid/edge constants (N, N_EDGE, widths).
  - FSM state enum.
  - Sentinel UNPLACED = -1.
- One sub-module, edge_dist: combinational |dx|, |dy|, Manhattan, 1-hop and Chebyshev terms plus the bad flag. It is registered in DIFF by the parent.

Test Plan:
- 2 edges, positions A(0,0)-B(3,2) and C(1,1)-D(1,2) -> cost_sum=4+0=4, cost_1hop=2+0=2, cost_max=5, err=0, done at cycle 11.
- Edge 1 has node B with pos_x=-1 -> edge 1 skipped, err=1, err_edge=1, other edges accumulated normally.
- Edge with coordinate 4 (N=4) at edge 0 and another bad edge at 3 -> err_edge stays 0.
- start pulsed while busy at cycle 3 -> ignored; results identical to a clean run; a second start after done reproduces the same values.
- reset_n dropped mid-evaluation (cycle 7) -> all outputs 0 asynchronously, idle, no reads issued; a subsequent start gives full-run values.
- COST_CHEBYSHEV_EN defined, edge (0,0)-(3,2) -> cost_cheb=2; undefined build compiles without the port.

Source files
------------

// File: rtl/placement_pkg.sv
// placement_pkg: grid/edge constants, evaluator FSM states and the unplaced sentinel
package placement_pkg;
  localparam int N       = 4;
  localparam int N_EDGE  = 19;
  localparam int EDGE_AW = 5;
  localparam int POS_AW  = 7;
  localparam int DW      = 32;
  localparam logic signed [DW-1:0] UNPLACED = -1;
  typedef enum logic [2:0] {IDLE, E_RD, A_RD, B_RD, DIFF, ACC, DONE} state_t;
  function automatic logic in_grid(input logic signed [DW-1:0] v);
    return (v >= 0) && (v < N);
  endfunction
endpackage

// File: rtl/edge_dist.sv
// edge_dist: combinational per-edge distance terms and off-grid/unplaced flag
// Chebyshev term present only when COST_CHEBYSHEV_EN is defined.
module edge_dist
  import placement_pkg::*;
(
  input  logic signed [DW-1:0] ax_i,
  input  logic signed [DW-1:0] ay_i,
  input  logic signed [DW-1:0] bx_i,
  input  logic signed [DW-1:0] by_i,
  output logic signed [DW-1:0] man_o,
  output logic signed [DW-1:0] hop_o,
`ifdef COST_CHEBYSHEV_EN
  output logic signed [DW-1:0] cheb_o,
`endif
  output logic                 bad_o
);
  logic signed [DW-1:0] dx, dy, adx, ady;
  always_comb begin
    dx    = ax_i - bx_i;
    dy    = ay_i - by_i;
    adx   = dx < 0 ? -dx : dx;
    ady   = dy < 0 ? -dy : dy;
    man_o = adx + ady;
    hop_o = (adx >> 1) + {{(DW-1){1'b0}}, adx[0]} + (ady >> 1) + {{(DW-1){1'b0}}, ady[0]};
`ifdef COST_CHEBYSHEV_EN
    cheb_o = adx > ady ? adx : ady;
`endif
    bad_o = !(in_grid(ax_i) && in_grid(ay_i) && in_grid(bx_i) && in_grid(by_i));
  end
endmodule

// File: rtl/placement_cost_eval.sv
// placement_cost_eval: walks the edge list, reads final positions, accumulates wirelength costs.
// Define COST_CHEBYSHEV_EN to add the cost_cheb accumulator and port.
module placement_cost_eval
  import placement_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      edge_re,
  output logic [EDGE_AW-1:0]        edge_addr,
  input  logic signed [DW-1:0]      edge_a,
  input  logic signed [DW-1:0]      edge_b,
  output logic                      pos_re,
  output logic [POS_AW-1:0]         pos_addr,
  input  logic signed [DW-1:0]      pos_x,
  input  logic signed [DW-1:0]      pos_y,
  output logic signed [DW-1:0]      cost_sum,
  output logic signed [DW-1:0]      cost_1hop,
  output logic signed [DW-1:0]      cost_max,
`ifdef COST_CHEBYSHEV_EN
  output logic signed [DW-1:0]      cost_cheb,
`endif
  output logic                      err,
  output logic [EDGE_AW-1:0]        err_edge
);
  state_t               state_q, state_d;
  logic [EDGE_AW-1:0]   i_q, i_d, err_edge_q, err_edge_d;
  logic [POS_AW-1:0]    b_q, b_d;
  logic signed [DW-1:0] ax_q, ax_d, ay_q, ay_d, man_q, man_d, hop_q, hop_d;
  logic signed [DW-1:0] sum_q, sum_d, hsum_q, hsum_d, max_q, max_d;
  logic                 bad_q, bad_d, err_q, err_d;
  logic signed [DW-1:0] man, hop;
  logic                 bad;
`ifdef COST_CHEBYSHEV_EN
  logic signed [DW-1:0] cheb, cheb_q, cheb_d, csum_q, csum_d;
`endif
  logic                 unused_hi;
  assign unused_hi = ^{edge_a[DW-1:POS_AW], edge_b[DW-1:POS_AW]};
  edge_dist u_dist (
    .ax_i  (ax_q),
    .ay_i  (ay_q),
    .bx_i  (pos_x),
    .by_i  (pos_y),
    .man_o (man),
    .hop_o (hop),
`ifdef COST_CHEBYSHEV_EN
    .cheb_o(cheb),
`endif
    .bad_o (bad)
  );
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    b_d        = b_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    man_d      = man_q;
    hop_d      = hop_q;
    bad_d      = bad_q;
    sum_d      = sum_q;
    hsum_d     = hsum_q;
    max_d      = max_q;
    err_d      = err_q;
    err_edge_d = err_edge_q;
`ifdef COST_CHEBYSHEV_EN
    cheb_d     = cheb_q;
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE, DONE: if (start) begin
        sum_d      = '0;
        hsum_d     = '0;
        max_d      = '0;
        err_d      = 1'b0;
        err_edge_d = '0;
        i_d        = '0;
`ifdef COST_CHEBYSHEV_EN
        csum_d     = '0;
`endif
        state_d    = (N_EDGE == 0) ? DONE : E_RD;
      end
      E_RD: state_d = A_RD;
      A_RD: begin
        b_d     = edge_b[POS_AW-1:0];
        state_d = B_RD;
      end
      B_RD: begin
        ax_d    = pos_x;
        ay_d    = pos_y;
        state_d = DIFF;
      end
      DIFF: begin
        man_d   = man;
        hop_d   = hop;
        bad_d   = bad;
`ifdef COST_CHEBYSHEV_EN
        cheb_d  = cheb;
`endif
        state_d = ACC;
      end
      ACC: begin
        if (!bad_q) begin
          sum_d  = sum_q + man_q - 1;
          hsum_d = hsum_q + hop_q - 1;
          max_d  = man_q > max_q ? man_q : max_q;
`ifdef COST_CHEBYSHEV_EN
          csum_d = csum_q + cheb_q - 1;
`endif
        end else if (!err_q) begin
          err_d      = 1'b1;
          err_edge_d = i_q;
        end
        if (i_q == EDGE_AW'(N_EDGE - 1)) state_d = DONE;
        else begin
          i_d     = i_q + 1'b1;
          state_d = E_RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      b_q        <= '0;
      ax_q       <= '0;
      ay_q       <= '0;
      man_q      <= '0;
      hop_q      <= '0;
      bad_q      <= 1'b0;
      sum_q      <= '0;
      hsum_q     <= '0;
      max_q      <= '0;
      err_q      <= 1'b0;
      err_edge_q <= '0;
`ifdef COST_CHEBYSHEV_EN
      cheb_q     <= '0;
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      b_q        <= b_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      man_q      <= man_d;
      hop_q      <= hop_d;
      bad_q      <= bad_d;
      sum_q      <= sum_d;
      hsum_q     <= hsum_d;
      max_q      <= max_d;
      err_q      <= err_d;
      err_edge_q <= err_edge_d;
`ifdef COST_CHEBYSHEV_EN
      cheb_q     <= cheb_d;
      csum_q     <= csum_d;
`endif
    end
  end
  assign busy      = !(state_q == IDLE || state_q == DONE);
  assign done      = state_q == DONE;
  assign edge_re   = state_q == E_RD;
  assign edge_addr = i_q;
  assign pos_re    = state_q == A_RD || state_q == B_RD;
  assign pos_addr  = state_q == A_RD ? edge_a[POS_AW-1:0] : state_q == B_RD ? b_q : '0;
  assign cost_sum  = sum_q;
  assign cost_1hop = hsum_q;
  assign cost_max  = max_q;
`ifdef COST_CHEBYSHEV_EN
  assign cost_cheb = csum_q;
`endif
  assign err       = err_q;
  assign err_edge  = err_edge_q;
endmodule

// File: tb/tb_placement_cost_eval.sv
// tb_placement_cost_eval: directed checks of placement_cost_eval against hand-computed costs
module tb_placement_cost_eval;
  import placement_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic busy, done, edge_re, pos_re, err;
  logic [EDGE_AW-1:0] edge_addr, err_edge;
  logic [POS_AW-1:0] pos_addr;
  logic signed [DW-1:0] edge_a = '0, edge_b = '0, pos_x = '0, pos_y = '0;
  logic signed [DW-1:0] cost_sum, cost_1hop, cost_max;
`ifdef COST_CHEBYSHEV_EN
  logic signed [DW-1:0] cost_cheb;
`endif
  logic signed [DW-1:0] ea [0:31], eb [0:31], px [0:127], py [0:127];
  int total = 0, bad = 0;

  placement_cost_eval dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .edge_re(edge_re), .edge_addr(edge_addr), .edge_a(edge_a), .edge_b(edge_b),
    .pos_re(pos_re), .pos_addr(pos_addr), .pos_x(pos_x), .pos_y(pos_y),
    .cost_sum(cost_sum), .cost_1hop(cost_1hop), .cost_max(cost_max),
`ifdef COST_CHEBYSHEV_EN
    .cost_cheb(cost_cheb),
`endif
    .err(err), .err_edge(err_edge)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (edge_re) begin
      edge_a <= ea[edge_addr];
      edge_b <= eb[edge_addr];
    end
    if (pos_re) begin
      pos_x <= px[pos_addr];
      pos_y <= py[pos_addr];
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // edges 0,1 are A(0,0)-B(3,2) and C(1,1)-D(1,2); all others are self-loops on node 0
  task automatic load_base();
    for (int k = 0; k < 32; k++) begin
      ea[k] = 0;
      eb[k] = 0;
    end
    for (int k = 0; k < 128; k++) begin
      px[k] = 0;
      py[k] = 0;
    end
    ea[0] = 0; eb[0] = 1;
    ea[1] = 2; eb[1] = 3;
    px[1] = 3; py[1] = 2;
    px[2] = 1; py[2] = 1;
    px[3] = 1; py[3] = 2;
    px[4] = UNPLACED; py[4] = 0;
    px[5] = 4; py[5] = 0;
  endtask

  task automatic run_eval(input string tag);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(94);
    chk({tag, "_done_early"}, done, 0);
    step(1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  task automatic check_res(input string tag, input int s, input int h, input int m,
                           input int c, input int e, input int ee);
    chk({tag, "_sum"}, cost_sum, s);
    chk({tag, "_1hop"}, cost_1hop, h);
    chk({tag, "_max"}, cost_max, m);
    chk({tag, "_err"}, err, e);
    chk({tag, "_err_edge"}, err_edge, ee);
`ifdef COST_CHEBYSHEV_EN
    chk({tag, "_cheb"}, cost_cheb, c);
`else
    if (c != c) $display("unreachable");
`endif
  endtask

  initial begin
    load_base();
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_edge_re", edge_re, 0);
    chk("rst_pos_re", pos_re, 0);
    chk("rst_sum", cost_sum, 0);
    chk("rst_err", err, 0);
    reset_n = 1'b1;
    step(1);

    // clean run: 4+0-17, 2+0-17, max 5, cheb 2+0-17
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("s1_busy", busy, 1);
    chk("s1_edge_re", edge_re, 1);
    chk("s1_edge_addr", edge_addr, 0);
    step(1);
    chk("s1_a_re", pos_re, 1);
    chk("s1_a_addr", pos_addr, 0);
    step(1);
    chk("s1_b_addr", pos_addr, 1);
    step(92);
    chk("s1_done_early", done, 0);
    step(1);
    chk("s1_done", done, 1);
    check_res("s1", -13, -15, 5, -15, 0, 0);

    // edge 1 ends on an unplaced node: skipped, would otherwise add 2 to cost_sum
    eb[1] = 4;
    run_eval("s2");
    check_res("s2", -13, -15, 5, -15, 1, 1);

    // off-grid node at edge 0, unplaced self-loop at edge 3: first bad index kept
    eb[1] = 3;
    ea[0] = 5; eb[0] = 0;
    ea[3] = 4; eb[3] = 4;
    run_eval("s3");
    check_res("s3", -16, -16, 1, -16, 1, 0);

    // start while busy is ignored
    load_base();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(91);
    chk("s4_done_early", done, 0);
    step(1);
    chk("s4_done", done, 1);
    check_res("s4", -13, -15, 5, -15, 0, 0);
    run_eval("s4b");
    check_res("s4b", -13, -15, 5, -15, 0, 0);

    // asynchronous reset mid-run after edge 0 already accumulated
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    chk("s5_mid_sum", cost_sum, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_done", done, 0);
    chk("s5_rst_sum", cost_sum, 0);
    chk("s5_rst_max", cost_max, 0);
    chk("s5_rst_1hop", cost_1hop, 0);
    step(2);
    chk("s5_rst_edge_re", edge_re, 0);
    chk("s5_rst_pos_re", pos_re, 0);
    reset_n = 1'b1;
    step(1);
    run_eval("s5");
    check_res("s5", -13, -15, 5, -15, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
